// File: rtl/mouse_click_ctl_if.sv
// Pointer/button stream into the click gesture controller and the
// click events plus latched press coordinates coming back out.
interface mouse_click_ctl_if;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic        mouse_left_in;
  logic        click_out;
  logic        dbl_click_out;
  logic        drag_out;
  logic [11:0] press_xpos;
  logic [11:0] press_ypos;

  modport master (
    output xpos_in, ypos_in, mouse_left_in,
    input  click_out, dbl_click_out, drag_out, press_xpos, press_ypos
  );

  modport slave (
    input  xpos_in, ypos_in, mouse_left_in,
    output click_out, dbl_click_out, drag_out, press_xpos, press_ypos
  );
endinterface

// File: rtl/mouse_click_ctl.sv
// Single-click / double-click / drag gesture controller on the buffered mouse stream.
// Define MOUSE_DOUBLE_CLICK_EN to build the double-click window (WAIT2/PRESS2).
module mouse_click_ctl #(
  parameter int DRAG_THRESH = 4,
  parameter int DBL_WINDOW  = 19_500_000
) (
  input  logic             pclk,
  input  logic             rst,
  mouse_click_ctl_if.slave bus
);

  if (DBL_WINDOW < 2) begin : g_bad_window
    $error("DBL_WINDOW must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
`ifdef MOUSE_DOUBLE_CLICK_EN
    WAIT2,
    PRESS2,
`endif
    DRAG
  } state_t;

  localparam logic [12:0] THRESH = 13'(DRAG_THRESH);

  state_t      state;
  logic        btn_q;
  logic        click_q;
  logic        dbl_q;
  logic        drag_q;
  logic [11:0] px_q;
  logic [11:0] py_q;

  logic        press_edge;
  logic        release_edge;
  logic [12:0] dx;
  logic [12:0] dy;
  logic [12:0] adx;
  logic [12:0] ady;
  logic        moved;

`ifdef MOUSE_DOUBLE_CLICK_EN
  localparam int CNT_W = $clog2(DBL_WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBL_WINDOW - 1);
  logic [CNT_W-1:0] cnt;
`endif

  assign press_edge   =  bus.mouse_left_in & ~btn_q;
  assign release_edge = ~bus.mouse_left_in &  btn_q;

  // Zero-extended 13-bit difference so 0 vs 4095 stays a full-scale distance.
  always_comb begin
    dx    = {1'b0, bus.xpos_in} - {1'b0, px_q};
    dy    = {1'b0, bus.ypos_in} - {1'b0, py_q};
    adx   = dx[12] ? (~dx + 13'd1) : dx;
    ady   = dy[12] ? (~dy + 13'd1) : dy;
    moved = (adx > THRESH) || (ady > THRESH);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= IDLE;
      btn_q   <= 1'b1;
      click_q <= 1'b0;
      dbl_q   <= 1'b0;
      drag_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
`ifdef MOUSE_DOUBLE_CLICK_EN
      cnt     <= '0;
`endif
    end else begin
      btn_q   <= bus.mouse_left_in;
      click_q <= 1'b0;
      dbl_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (press_edge) begin
            state <= PRESS;
            px_q  <= bus.xpos_in;
            py_q  <= bus.ypos_in;
          end
        end
        PRESS: begin
          if (release_edge) begin
`ifdef MOUSE_DOUBLE_CLICK_EN
            state <= WAIT2;
            cnt   <= '0;
`else
            state   <= IDLE;
            click_q <= 1'b1;
`endif
          end else if (moved) begin
            state  <= DRAG;
            drag_q <= 1'b1;
          end
        end
`ifdef MOUSE_DOUBLE_CLICK_EN
        WAIT2: begin
          cnt <= cnt + CNT_W'(1);
          // A second press beats window expiry even on the last window cycle.
          if (press_edge) begin
            state <= PRESS2;
            px_q  <= bus.xpos_in;
            py_q  <= bus.ypos_in;
          end else if (moved || cnt == CNT_LAST) begin
            state   <= IDLE;
            click_q <= 1'b1;
          end
        end
        PRESS2: begin
          if (release_edge) begin
            state <= IDLE;
            dbl_q <= 1'b1;
          end else if (moved) begin
            state   <= DRAG;
            click_q <= 1'b1;
            drag_q  <= 1'b1;
          end
        end
`endif
        DRAG: begin
          if (release_edge) begin
            state  <= IDLE;
            drag_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          drag_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.click_out     = click_q;
  assign bus.dbl_click_out = dbl_q;
  assign bus.drag_out      = drag_q;
  assign bus.press_xpos    = px_q;
  assign bus.press_ypos    = py_q;

endmodule
